// File: rtl/acsi_pkg.sv
// Shared definitions for the ACSI data-phase FIFO.
//   ACSI_BYTE_W  : width of one ACSI bus byte
//   acsi_state_t : data-phase handshake state encoding
//   acsi_in_xfer : true while a transfer is in progress (REQ/ACKWAIT/HOLD)
package acsi_pkg;

  localparam int ACSI_BYTE_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_REQ     = 3'd1,
    ST_ACKWAIT = 3'd2,
    ST_HOLD    = 3'd3,
    ST_DONE    = 3'd4
  } acsi_state_t;

  function automatic logic acsi_in_xfer(input acsi_state_t s);
    return (s == ST_REQ) || (s == ST_ACKWAIT) || (s == ST_HOLD);
  endfunction

endpackage

// File: rtl/acsi_sync_fifo.sv
// Synchronous FIFO with flush, used as the byte buffer between the AVR and
// the ACSI host.
//   i_clk / i_srst : clock, synchronous active-high reset
//   i_flush        : empties the FIFO (pointers and count to zero)
//   i_push/i_wdata : write strobe and data; ignored when full unless a pop
//                    happens in the same cycle
//   i_pop          : read strobe; ignored when empty
//   o_head         : current head entry, visible without read latency
//   o_count        : number of stored entries, 0..DEPTH
module acsi_sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                   i_clk,
  input  logic                   i_srst,
  input  logic                   i_flush,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_wdata,
  input  logic                   i_pop,
  output logic [WIDTH-1:0]       o_head,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_empty;
  logic w_full;
  logic w_pop_ok;
  logic w_push_ok;

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == CNT_W'(DEPTH));
  assign w_pop_ok  = i_pop && !w_empty;
  // When full, a same-cycle pop frees the slot first, so the push is kept.
  assign w_push_ok = i_push && (!w_full || w_pop_ok);

  // Storage has no reset; only the pointers/count define what is valid.
  always_ff @(posedge i_clk) begin
    if (w_push_ok && !i_flush) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge i_clk) begin
    if (i_srst || i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // The host samples the head while DRQ is asserted, so it must be visible
  // combinationally rather than through a registered RAM read.
  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/acsi_data_fifo.sv
// ACSI data-phase engine: buffers bytes between the AVR and the Atari host
// and runs the DRQ/ACK DMA handshake.
//   clock, reset        : sole clock, synchronous active-high reset
//   dir                 : 0 host writes (host->AVR), 1 host reads (AVR->host)
//   start, abort        : one-cycle pulses; start loads xfer_len and flushes
//   xfer_len            : byte count of the data phase (0 = nothing to move)
//   a_wr/a_wdata        : AVR push (dir=1)
//   a_rd/a_rdata        : AVR pop (dir=0), a_rdata is the FIFO head
//   a_int               : AVR may strobe now
//   f_ack_n             : asynchronous host acknowledge (active low)
//   f_wdata/f_rdata     : host-side data in/out, f_oe enables bus drive
//   f_drq_n             : active-low DMA request to the host
//   remaining/done/err  : bytes left, phase complete, sticky misuse flag
module acsi_data_fifo
  import acsi_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int LEN_W = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   dir,
  input  logic                   start,
  input  logic                   abort,
  input  logic [LEN_W-1:0]       xfer_len,
  input  logic                   a_wr,
  input  logic [ACSI_BYTE_W-1:0] a_wdata,
  input  logic                   a_rd,
  output logic [ACSI_BYTE_W-1:0] a_rdata,
  output logic                   a_int,
  input  logic                   f_ack_n,
  input  logic [ACSI_BYTE_W-1:0] f_wdata,
  output logic [ACSI_BYTE_W-1:0] f_rdata,
  output logic                   f_oe,
  output logic                   f_drq_n,
  output logic [LEN_W-1:0]       remaining,
  output logic                   done,
  output logic                   err
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  acsi_state_t      r_state;
  logic             r_dir;
  logic             r_drq_n;
  logic             r_oe;
  logic             r_done;
  logic             r_err;
  logic             r_a_int;
  logic [LEN_W-1:0] r_remaining;
  logic             r_ack_meta;
  logic             r_ack_s;

  logic [CNT_W-1:0]       w_count;
  logic                   w_empty;
  logic                   w_full;
  logic                   w_active;
  logic                   w_host_xfer;
  logic                   w_host_pop;
  logic                   w_host_push;
  logic                   w_avr_wr_ok;
  logic                   w_avr_rd_ok;
  logic                   w_avr_bad;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_flush;
  logic [ACSI_BYTE_W-1:0] w_push_data;
  logic [ACSI_BYTE_W-1:0] w_head;

  // Two-flop synchronizer; idles high so a reset never looks like an ACK.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_ack_meta <= 1'b1;
      r_ack_s    <= 1'b1;
    end else begin
      r_ack_meta <= f_ack_n;
      r_ack_s    <= r_ack_meta;
    end
  end

  assign w_empty  = (w_count == '0);
  assign w_full   = (w_count == CNT_W'(DEPTH));
  assign w_active = acsi_in_xfer(r_state);

  // The byte moves on the edge where ack_s becomes 0 (first flop already
  // low), so DRQ is released on that same edge and never overlaps ack_s=0.
  assign w_host_xfer = (r_state == ST_ACKWAIT) && !r_ack_meta;
  assign w_host_pop  = w_host_xfer && r_dir;
  assign w_host_push = w_host_xfer && !r_dir;

  assign w_avr_wr_ok = a_wr && w_active && r_dir && (!w_full || w_host_pop);
  assign w_avr_rd_ok = a_rd && w_active && !r_dir && !w_empty;
  assign w_avr_bad   = (a_wr && !w_avr_wr_ok) || (a_rd && !w_avr_rd_ok);

  assign w_push      = w_avr_wr_ok || w_host_push;
  assign w_pop       = w_avr_rd_ok || w_host_pop;
  assign w_push_data = r_dir ? a_wdata : f_wdata;
  assign w_flush     = start || abort;

  acsi_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ACSI_BYTE_W)
  ) u_fifo (
    .i_clk   (clock),
    .i_srst  (reset),
    .i_flush (w_flush),
    .i_push  (w_push),
    .i_wdata (w_push_data),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_count (w_count)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_dir       <= 1'b0;
      r_drq_n     <= 1'b1;
      r_oe        <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_a_int     <= 1'b0;
      r_remaining <= '0;
    end else if (abort) begin
      // err is deliberately kept so the AVR can inspect it after aborting.
      r_state     <= ST_IDLE;
      r_drq_n     <= 1'b1;
      r_oe        <= 1'b0;
      r_done      <= 1'b0;
      r_a_int     <= 1'b0;
      r_remaining <= '0;
    end else if (start) begin
      r_dir       <= dir;
      r_err       <= 1'b0;
      r_a_int     <= 1'b0;
      r_drq_n     <= 1'b1;
      r_remaining <= xfer_len;
      if (xfer_len != '0) begin
        r_state <= ST_REQ;
        r_oe    <= dir;
        r_done  <= 1'b0;
      end else begin
        r_state <= ST_DONE;
        r_oe    <= 1'b0;
        r_done  <= 1'b1;
      end
    end else begin
      if (w_avr_bad) begin
        r_err <= 1'b1;
      end
      r_a_int <= w_active && (r_dir ? !w_full : !w_empty);
      case (r_state)
        ST_REQ: begin
          // Both synchronizer flops high: ack_s stays 1 across the edge
          // that asserts DRQ.
          if (r_ack_s && r_ack_meta && (r_dir ? !w_empty : !w_full)) begin
            r_drq_n <= 1'b0;
            r_state <= ST_ACKWAIT;
          end
        end
        ST_ACKWAIT: begin
          if (w_host_xfer) begin
            r_drq_n     <= 1'b1;
            r_remaining <= r_remaining - LEN_W'(1);
            r_state     <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (r_ack_s) begin
            if (r_remaining != '0) begin
              r_state <= ST_REQ;
            end else if (r_dir || w_empty) begin
              // Host-write phases finish only once the AVR has drained.
              r_state <= ST_DONE;
              r_done  <= 1'b1;
              r_oe    <= 1'b0;
            end
          end
        end
        default: begin
          r_state <= r_state;
        end
      endcase
    end
  end

  assign a_rdata   = w_head;
  assign f_rdata   = w_head;
  assign a_int     = r_a_int;
  assign f_oe      = r_oe;
  assign f_drq_n   = r_drq_n;
  assign remaining = r_remaining;
  assign done      = r_done;
  assign err       = r_err;

endmodule

// File: tb/tb_acsi_data_fifo.sv
module tb_acsi_data_fifo;

  logic        clk = 1'b0;
  logic        reset;
  logic        dir, start, abort;
  logic [15:0] xfer_len;
  logic        a_wr, a_rd;
  logic [7:0]  a_wdata, a_rdata;
  logic        a_int;
  logic        f_ack_n;
  logic [7:0]  f_wdata, f_rdata;
  logic        f_oe, f_drq_n;
  logic [15:0] remaining;
  logic        done, err;

  logic        d4_dir, d4_start, d4_abort, d4_a_wr, d4_a_rd, d4_f_ack_n;
  logic [15:0] d4_len;
  logic [7:0]  d4_a_wdata, d4_a_rdata, d4_f_wdata, d4_f_rdata;
  logic        d4_a_int, d4_f_oe, d4_f_drq_n, d4_done, d4_err;
  logic [15:0] d4_remaining;

  always #5 clk = ~clk;

  acsi_data_fifo #(.DEPTH(16), .LEN_W(16)) u_dut (
    .clock(clk), .reset(reset), .dir(dir), .start(start), .abort(abort),
    .xfer_len(xfer_len), .a_wr(a_wr), .a_wdata(a_wdata), .a_rd(a_rd),
    .a_rdata(a_rdata), .a_int(a_int), .f_ack_n(f_ack_n), .f_wdata(f_wdata),
    .f_rdata(f_rdata), .f_oe(f_oe), .f_drq_n(f_drq_n),
    .remaining(remaining), .done(done), .err(err)
  );

  acsi_data_fifo #(.DEPTH(4), .LEN_W(16)) u_dut4 (
    .clock(clk), .reset(reset), .dir(d4_dir), .start(d4_start), .abort(d4_abort),
    .xfer_len(d4_len), .a_wr(d4_a_wr), .a_wdata(d4_a_wdata), .a_rd(d4_a_rd),
    .a_rdata(d4_a_rdata), .a_int(d4_a_int), .f_ack_n(d4_f_ack_n), .f_wdata(d4_f_wdata),
    .f_rdata(d4_f_rdata), .f_oe(d4_f_oe), .f_drq_n(d4_f_drq_n),
    .remaining(d4_remaining), .done(d4_done), .err(d4_err)
  );

  int n_checks = 0;
  int n_errs   = 0;
  logic [7:0] sb_q[$];

  typedef struct {
    logic        dir;
    logic [15:0] len;
    logic        wr;
    logic        rd;
    logic        exp_err;
    logic        exp_done;
    logic        exp_oe;
    logic        exp_drq_n;
    logic        exp_a_int;
    logic [15:0] exp_rem;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic d, input logic [15:0] len);
    dir = d; xfer_len = len; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_abort();
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  function automatic int sb_pop();
    if (sb_q.size() == 0) return -1;
    return int'(sb_q.pop_front());
  endfunction

  // Host side of one DRQ/ACK handshake; ok=0 if DRQ never shows up or never drops.
  task automatic host_xfer(input logic [7:0] wd, output logic [7:0] rd, output bit ok);
    int n;
    ok = 1'b0; rd = 8'h00;
    n = 0;
    while (f_drq_n && n < 60) begin tick(); n++; end
    if (f_drq_n) return;
    f_wdata = wd; rd = f_rdata; f_ack_n = 1'b0;
    n = 0;
    while (!f_drq_n && n < 60) begin tick(); n++; end
    tick();
    f_ack_n = 1'b1;
    tick();
    ok = f_drq_n;
  endtask

  task automatic avr_read();
    check("avr_rdata", int'(a_rdata), sb_pop());
    a_rd = 1'b1;
    tick();
    a_rd = 1'b0;
  endtask

  task automatic wait_done(output bit seen);
    int n;
    n = 0;
    while (!done && n < 40) begin tick(); n++; end
    seen = done;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rd, wd;
    logic [7:0] bytes4 [4];
    logic [7:0] d4_vals [5];
    bit ok, seen_low, seen;

    reset = 1'b1; dir = 1'b0; start = 1'b0; abort = 1'b0; xfer_len = '0;
    a_wr = 1'b0; a_rd = 1'b0; a_wdata = '0; f_ack_n = 1'b1; f_wdata = '0;
    d4_dir = 1'b0; d4_start = 1'b0; d4_abort = 1'b0; d4_a_wr = 1'b0; d4_a_rd = 1'b0;
    d4_f_ack_n = 1'b1; d4_len = '0; d4_a_wdata = '0; d4_f_wdata = '0;

    //            dir    len     wr    rd    err   done  oe    drq_n a_int rem
    vecs[0] = '{1'b1, 16'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 16'd4};
    vecs[1] = '{1'b1, 16'd4, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 16'd4};
    vecs[2] = '{1'b0, 16'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd3};
    vecs[3] = '{1'b0, 16'd4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd4};
    vecs[4] = '{1'b0, 16'd4, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd4};
    vecs[5] = '{1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'd0};
    vecs[6] = '{1'b1, 16'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'd0};
    vecs[7] = '{1'b1, 16'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 16'd5};

    bytes4[0] = 8'h55; bytes4[1] = 8'hAA; bytes4[2] = 8'h01; bytes4[3] = 8'hFF;
    d4_vals[0] = 8'h11; d4_vals[1] = 8'h22; d4_vals[2] = 8'h33;
    d4_vals[3] = 8'h44; d4_vals[4] = 8'h99;

    // Reset values
    repeat (3) tick();
    check("rst_drq_n", f_drq_n, 1);   check("rst_oe", f_oe, 0);
    check("rst_a_int", a_int, 0);     check("rst_done", done, 0);
    check("rst_err", err, 0);         check("rst_rem", remaining, 0);
    check("rst4_drq_n", d4_f_drq_n, 1);
    reset = 1'b0;
    tick();
    $display("tx reset: outputs checked");

    // Table-driven single-strobe vectors
    for (int i = 0; i < 8; i++) begin
      pulse_start(vecs[i].dir, vecs[i].len);
      a_wr = vecs[i].wr; a_rd = vecs[i].rd; a_wdata = 8'h5A;
      tick();
      a_wr = 1'b0; a_rd = 1'b0;
      check($sformatf("v%0d_err", i),   err,       vecs[i].exp_err);
      check($sformatf("v%0d_done", i),  done,      vecs[i].exp_done);
      check($sformatf("v%0d_oe", i),    f_oe,      vecs[i].exp_oe);
      check($sformatf("v%0d_drq", i),   f_drq_n,   vecs[i].exp_drq_n);
      check($sformatf("v%0d_aint", i),  a_int,     vecs[i].exp_a_int);
      check($sformatf("v%0d_rem", i),   remaining, vecs[i].exp_rem);
      $display("tx vec %0d: dir=%0d len=%0d wr=%0d rd=%0d err=%0d done=%0d",
               i, vecs[i].dir, vecs[i].len, vecs[i].wr, vecs[i].rd, err, done);
    end
    pulse_abort();

    // Host read of four AVR-supplied bytes
    sb_q.delete();
    pulse_start(1'b1, 16'd4);
    for (int i = 0; i < 4; i++) begin
      a_wdata = bytes4[i]; a_wr = 1'b1; sb_q.push_back(bytes4[i]);
      tick();
    end
    a_wr = 1'b0;
    check("rd4_oe", f_oe, 1);
    for (int i = 0; i < 4; i++) begin
      host_xfer(8'h00, rd, ok);
      check("rd4_xfer_ok", ok, 1);
      check("rd4_data", rd, sb_pop());
      check("rd4_rem", remaining, 3 - i);
      $display("tx host read %0d: data=%02h remaining=%0d", i, rd, remaining);
    end
    wait_done(seen);
    check("rd4_done", seen, 1); check("rd4_oe_off", f_oe, 0); check("rd4_err", err, 0);

    // ACK held low: DRQ must wait for the synchronized release
    f_ack_n = 1'b0;
    repeat (3) tick();
    pulse_start(1'b1, 16'd2);
    a_wdata = 8'h3C; a_wr = 1'b1;
    tick();
    a_wr = 1'b0;
    seen_low = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (!f_drq_n) seen_low = 1'b1;
    end
    check("acklow_no_drq", seen_low, 0);
    f_ack_n = 1'b1;
    tick(); tick();
    check("acklow_drq_early", f_drq_n, 1);
    tick();
    check("acklow_drq_3cyc", f_drq_n, 0);
    check("acklow_head", f_rdata, 8'h3C);
    $display("tx ack-low hold: drq_n=%0d after 3 cycles", f_drq_n);
    pulse_abort();
    check("abort_drq_n", f_drq_n, 1); check("abort_rem", remaining, 0);
    check("abort_oe", f_oe, 0);       check("abort_aint", a_int, 0);

    // Abort after 2 of 8 host-write bytes, then zero-length start
    sb_q.delete();
    pulse_start(1'b0, 16'd8);
    for (int i = 0; i < 2; i++) begin
      wd = 8'hC0 + 8'(i);
      host_xfer(wd, rd, ok);
      check("ab_xfer_ok", ok, 1);
      $display("tx host write %0d: data=%02h", i, wd);
    end
    check("ab_rem6", remaining, 6); check("ab_aint_pre", a_int, 1);
    pulse_abort();
    check("ab_drq_n", f_drq_n, 1); check("ab_aint", a_int, 0);
    check("ab_rem", remaining, 0); check("ab_done", done, 0);
    pulse_start(1'b0, 16'd0);
    check("len0_done", done, 1); check("len0_drq_n", f_drq_n, 1);
    $display("tx abort + len0 start: done=%0d", done);

    // 256-byte host write through a 16-deep FIFO with AVR stall
    sb_q.delete();
    pulse_start(1'b0, 16'd256);
    for (int i = 0; i < 16; i++) begin
      wd = 8'($urandom);
      host_xfer(wd, rd, ok);
      check("w256_fill_ok", ok, 1);
      if (ok) sb_q.push_back(wd);
    end
    seen_low = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (!f_drq_n) seen_low = 1'b1;
    end
    check("w256_full_no_drq", seen_low, 0);
    check("w256_aint", a_int, 1); check("w256_rem240", remaining, 240);
    $display("tx w256 stall at full: remaining=%0d", remaining);
    avr_read();
    for (int i = 16; i < 256; i++) begin
      wd = 8'($urandom);
      host_xfer(wd, rd, ok);
      check("w256_xfer_ok", ok, 1);
      if (ok) sb_q.push_back(wd);
      avr_read();
    end
    while (sb_q.size() > 0) avr_read();
    wait_done(seen);
    check("w256_done", seen, 1); check("w256_err", err, 0);
    check("w256_rem", remaining, 0);
    $display("tx w256 complete: done=%0d err=%0d", done, err);

    // DEPTH=4 overflow
    d4_dir = 1'b1; d4_len = 16'd8; d4_start = 1'b1;
    tick();
    d4_start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      d4_a_wdata = d4_vals[k]; d4_a_wr = 1'b1;
      tick();
      if (k == 3) begin
        check("d4_err_pre", d4_err, 0); check("d4_aint_pre", d4_a_int, 1);
      end
    end
    d4_a_wr = 1'b0;
    check("d4_err", d4_err, 1); check("d4_aint_full", d4_a_int, 0);
    tick();
    check("d4_aint_full2", d4_a_int, 0); check("d4_head", d4_f_rdata, 8'h11);
    check("d4_drq", d4_f_drq_n, 0);
    $display("tx depth4 overflow: err=%0d a_int=%0d head=%02h", d4_err, d4_a_int, d4_f_rdata);
    d4_abort = 1'b1;
    tick();
    d4_abort = 1'b0;
    check("d4_err_held", d4_err, 1); check("d4_abort_drq", d4_f_drq_n, 1);

    // Reset during ACKWAIT
    pulse_start(1'b1, 16'd2);
    a_wdata = 8'h77; a_wr = 1'b1;
    tick();
    a_wr = 1'b0;
    begin
      int n;
      n = 0;
      while (f_drq_n && n < 20) begin tick(); n++; end
    end
    check("rw_drq_asserted", f_drq_n, 0);
    reset = 1'b1;
    tick();
    check("rw_drq_n", f_drq_n, 1); check("rw_oe", f_oe, 0);
    check("rw_aint", a_int, 0);    check("rw_done", done, 0);
    check("rw_err", err, 0);       check("rw_rem", remaining, 0);
    reset = 1'b0;
    tick();
    $display("tx reset in ACKWAIT: drq_n=%0d", f_drq_n);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
